// File: rtl/memory_ram_loader.sv
// ---------------------------------------------------------------------------
// Module : memory_ram_loader
// Purpose: Runtime-loadable replacement for the 16x16 lookup ROM. A byte
//          stream arriving over a valid/ready handshake is packed into 16-bit
//          words (high byte first). The words are written to addresses
//          0..DEPTH-1 of an internal RAM. The read side matches the ROM: a
//          registered port with one cycle of latency.
//
// Optional feature (macro CHECKSUM_EN):
//   When defined, the loader XORs every data byte of a transfer. After the
//   last word it accepts one extra checksum byte and flags a mismatch on err.
//   When undefined, err is tied low. There is no CHECK state and no XOR
//   register.
//
// Ports:
//   clk       in   1           rising-edge clock
//   rst       in   1           synchronous, active-high reset
//   start     in   1           begin a load at address 0 (honoured in IDLE/DONE)
//   in_valid  in   1           in_byte carries a valid stream byte
//   in_byte   in   8           stream byte
//   in_ready  out  1           loader accepts a byte this cycle
//   busy      out  1           transfer in progress
//   done      out  1           sticky transfer-complete flag
//   err       out  1           sticky checksum mismatch flag
//   en        in   1           read enable
//   address   in   ADDR_WIDTH  read address
//   out       out  DATA_WIDTH  registered read data
// ---------------------------------------------------------------------------
module memory_ram_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] out
);

    // The RAM always spans the full address space. Reads beyond DEPTH return
    // whatever happens to be stored there.
    localparam int                    MEM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_HI,
        S_LOAD_LO,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_hiByte;
    logic [7:0]            r_loByte;
    logic                  r_inReady;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_out;

    logic                  w_accept;
    logic                  w_lastWord;
    logic [DATA_WIDTH-1:0] w_wordData;

`ifdef CHECKSUM_EN
    logic [7:0]            r_xor;
    logic                  r_err;
`endif

    // A byte moves across the interface only when both sides agree. Ready
    // comes from a register, so it depends on the state alone and never on
    // in_valid.
    assign w_accept   = in_valid && r_inReady;
    assign w_lastWord = (r_waddr == LAST_ADDR);
    assign w_wordData = {r_hiByte, r_loByte};

    assign in_ready = r_inReady;
    assign busy     = r_busy;
    assign done     = r_done;
    assign out      = r_out;

`ifdef CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Loader sequencer. Each word goes through three states: high byte, low
    // byte, then one WRITE cycle. The handshake and status outputs are
    // registered here. They are updated on the same edge as the state
    // transition, so they always describe the state being entered. A start
    // pulse restarts the transfer only from IDLE or DONE. Pulses that arrive
    // mid-transfer fall through the case arms without effect. Reset drops any
    // half-assembled word. Words already committed to the RAM stay there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_waddr   <= '0;
            r_hiByte  <= '0;
            r_loByte  <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef CHECKSUM_EN
            r_xor     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_LOAD_HI;
                        r_waddr   <= '0;
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
`ifdef CHECKSUM_EN
                        r_xor     <= '0;
                        r_err     <= 1'b0;
`endif
                    end
                end

                S_LOAD_HI: begin
                    if (w_accept) begin
                        r_hiByte <= in_byte;
                        r_state  <= S_LOAD_LO;
`ifdef CHECKSUM_EN
                        r_xor    <= r_xor ^ in_byte;
`endif
                    end
                end

                S_LOAD_LO: begin
                    if (w_accept) begin
                        r_loByte  <= in_byte;
                        r_state   <= S_WRITE;
                        r_inReady <= 1'b0;
`ifdef CHECKSUM_EN
                        r_xor     <= r_xor ^ in_byte;
`endif
                    end
                end

                S_WRITE: begin
                    r_waddr <= r_waddr + ADDR_WIDTH'(1);
                    if (w_lastWord) begin
`ifdef CHECKSUM_EN
                        r_state   <= S_CHECK;
                        r_inReady <= 1'b1;
`else
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
`endif
                    end else begin
                        r_state   <= S_LOAD_HI;
                        r_inReady <= 1'b1;
                    end
                end

`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_err     <= (in_byte != r_xor);
                        r_state   <= S_DONE;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
`endif

                default: begin
                    r_state   <= S_IDLE;
                    r_inReady <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port. The assembled word is committed on the edge that ends
    // the WRITE state. Reset has no path into the array, so its contents
    // survive reset. A reset that arrives during WRITE cancels that write,
    // because the loader is aborting.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_WRITE)) begin
            r_mem[r_waddr] <= w_wordData;
        end
    end

    // Registered read port. It runs independently of the loader. It is
    // sampled on the same edge as the write port, so a read and a write to
    // the same address return the old word (read-before-write). A disabled
    // read returns zero, matching the ROM it replaces.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= en ? r_mem[address] : '0;
        end
    end

endmodule

// File: tb/tb_memory_ram_loader.sv
// ---------------------------------------------------------------------------
// Testbench for memory_ram_loader. Directed scenarios with hand-computed
// expected words. A small handshake model predicts in_ready and tells the
// bench which stream byte to present on each cycle.
// ---------------------------------------------------------------------------
module tb_memory_ram_loader;

`ifdef CHECKSUM_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        en;
    logic [3:0]  address;
    logic [15:0] out;

    int checks;
    int failures;

    int mPhase;
    int mWord;
    int mIdx;
    logic [7:0] seqBytes [0:63];

    memory_ram_loader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_ready(in_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .en(en),
        .address(address),
        .out(out)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; inputs and outputs are handled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill the stream: specPattern gives word k = {k, k*0x11}, otherwise
    // {hiBase+k, loBase+k}; the checksum byte goes last, xored with ckFlip
    task automatic fillPattern(input bit specPattern, input logic [7:0] hiBase,
                               input logic [7:0] loBase, input logic [7:0] ckFlip);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 16; k++) begin
            seqBytes[2*k]   = specPattern ? 8'(k) : 8'(hiBase + 8'(k));
            seqBytes[2*k+1] = specPattern ? 8'(k * 17) : 8'(loBase + 8'(k));
            x = x ^ seqBytes[2*k] ^ seqBytes[2*k+1];
        end
        seqBytes[32] = x ^ ckFlip;
        for (int k = 33; k < 64; k++) seqBytes[k] = 8'h00;
    endtask

    // Pulse start for one cycle and reset the handshake model
    task automatic beginLoad();
        start = 1'b1;
        tick();
        start = 1'b0;
        mPhase = 0;
        mWord  = 0;
        mIdx   = 0;
    endtask

    // Drive the stream for up to maxCycles cycles, or until done rises.
    // Model phases: 0 high byte, 1 low byte, 2 write, 3 checksum, 4 done.
    task automatic runLoad(input bit toggleValid, input int maxCycles,
                           output int cycles, output int readyErrs);
        bit expReady;
        bit acc;
        cycles    = 0;
        readyErrs = 0;
        while (cycles < maxCycles) begin
            in_valid = toggleValid ? ((cycles % 2) == 0) : 1'b1;
            in_byte  = seqBytes[mIdx];
            expReady = (mPhase == 0) || (mPhase == 1) || (mPhase == 3);
            if (in_ready !== expReady) readyErrs++;
            acc = in_valid && expReady;
            tick();
            cycles++;
            case (mPhase)
                0: if (acc) begin mIdx++; mPhase = 1; end
                1: if (acc) begin mIdx++; mPhase = 2; end
                2: begin
                    mWord++;
                    mPhase = (mWord == 16) ? ((CHK_EN != 0) ? 3 : 4) : 0;
                end
                3: if (acc) begin mIdx++; mPhase = 4; end
                default: ;
            endcase
            if (done === 1'b1) break;
        end
        in_valid = 1'b0;
    endtask

    // Registered read: returns the data that appears one edge after the request
    task automatic readWord(input logic [3:0] addr, output logic [15:0] data);
        en      = 1'b1;
        address = addr;
        tick();
        data = out;
        en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (out !== 16'h0000) begin failures++; $display("[TB] FAIL reset_out: got %h expected 0000", out); end
    endtask

    task automatic test_full_load();
        int cyc;
        int rdyErr;
        logic [15:0] d;
        fillPattern(1'b1, 8'h00, 8'h00, 8'h00);
        beginLoad();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL load_busy: got %b expected 1", busy); end
        runLoad(1'b0, 200, cyc, rdyErr);
        checks++;
        if (cyc !== 48 + CHK_EN) begin failures++; $display("[TB] FAIL load_done_cycle: got %0d expected %0d", cyc, 48 + CHK_EN); end
        checks++;
        if (rdyErr !== 0) begin failures++; $display("[TB] FAIL load_ready_pattern: got %0d errors expected 0", rdyErr); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL load_busy_end: got %b expected 0", busy); end
        readWord(4'd3, d);
        checks++;
        if (d !== 16'h0333) begin failures++; $display("[TB] FAIL read_addr3: got %h expected 0333", d); end
        readWord(4'd15, d);
        checks++;
        if (d !== 16'h0FFF) begin failures++; $display("[TB] FAIL read_addr15: got %h expected 0fff", d); end
        readWord(4'd1, d);
        checks++;
        if (d !== 16'h0111) begin failures++; $display("[TB] FAIL read_addr1: got %h expected 0111", d); end
    endtask

    task automatic test_reset_midload();
        int cyc;
        int rdyErr;
        logic [15:0] d;
        fillPattern(1'b0, 8'h50, 8'hC0, 8'h00);
        beginLoad();
        runLoad(1'b0, 7, cyc, rdyErr);
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        rst = 1'b0;
        tick();
        readWord(4'd0, d);
        checks++;
        if (d !== 16'h50C0) begin failures++; $display("[TB] FAIL midrst_mem0: got %h expected 50c0", d); end
        readWord(4'd1, d);
        checks++;
        if (d !== 16'h51C1) begin failures++; $display("[TB] FAIL midrst_mem1: got %h expected 51c1", d); end
        readWord(4'd2, d);
        checks++;
        if (d !== 16'h0222) begin failures++; $display("[TB] FAIL midrst_mem2_kept: got %h expected 0222", d); end
    endtask

    task automatic test_read_port();
        int cyc;
        int rdyErr;
        en      = 1'b1;
        address = 4'd5;
        tick();
        checks++;
        if (out !== 16'h0555) begin failures++; $display("[TB] FAIL read_en1: got %h expected 0555", out); end
        en = 1'b0;
        tick();
        checks++;
        if (out !== 16'h0000) begin failures++; $display("[TB] FAIL read_en0: got %h expected 0000", out); end
        // Word 5 is written on the 18th edge after start; read addr 5 on that edge
        fillPattern(1'b0, 8'h50, 8'hC0, 8'h00);
        beginLoad();
        runLoad(1'b0, 17, cyc, rdyErr);
        en      = 1'b1;
        address = 4'd5;
        runLoad(1'b0, 1, cyc, rdyErr);
        checks++;
        if (out !== 16'h0555) begin failures++; $display("[TB] FAIL rbw_old: got %h expected 0555", out); end
        runLoad(1'b0, 1, cyc, rdyErr);
        checks++;
        if (out !== 16'h55C5) begin failures++; $display("[TB] FAIL rbw_new: got %h expected 55c5", out); end
        en = 1'b0;
        runLoad(1'b0, 200, cyc, rdyErr);
        checks++;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL rbw_load_done: got %b expected 1", done); end
    endtask

    task automatic test_start_control();
        int c1;
        int c2;
        int c3;
        int rdyErr;
        logic [15:0] d;
        // Start pulse while busy, during the low-byte phase of word 1
        fillPattern(1'b0, 8'h30, 8'hE0, 8'h00);
        beginLoad();
        runLoad(1'b0, 4, c1, rdyErr);
        start = 1'b1;
        runLoad(1'b0, 1, c2, rdyErr);
        start = 1'b0;
        runLoad(1'b0, 200, c3, rdyErr);
        checks++;
        if (c1 + c2 + c3 !== 48 + CHK_EN) begin failures++; $display("[TB] FAIL busy_start_cycles: got %0d expected %0d", c1 + c2 + c3, 48 + CHK_EN); end
        checks++;
        if (rdyErr !== 0) begin failures++; $display("[TB] FAIL busy_start_ready: got %0d errors expected 0", rdyErr); end
        readWord(4'd0, d);
        checks++;
        if (d !== 16'h30E0) begin failures++; $display("[TB] FAIL busy_start_mem0: got %h expected 30e0", d); end
        readWord(4'd1, d);
        checks++;
        if (d !== 16'h31E1) begin failures++; $display("[TB] FAIL busy_start_mem1: got %h expected 31e1", d); end
        readWord(4'd15, d);
        checks++;
        if (d !== 16'h3FEF) begin failures++; $display("[TB] FAIL busy_start_mem15: got %h expected 3fef", d); end
        // Start from DONE begins a fresh load at address 0
        fillPattern(1'b0, 8'h80, 8'h40, 8'h00);
        beginLoad();
        checks++;
        if (done !== 1'b0) begin failures++; $display("[TB] FAIL restart_done: got %b expected 0", done); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL restart_busy: got %b expected 1", busy); end
        runLoad(1'b0, 200, c3, rdyErr);
        checks++;
        if (c3 !== 48 + CHK_EN) begin failures++; $display("[TB] FAIL restart_cycles: got %0d expected %0d", c3, 48 + CHK_EN); end
        readWord(4'd0, d);
        checks++;
        if (d !== 16'h8040) begin failures++; $display("[TB] FAIL restart_mem0: got %h expected 8040", d); end
    endtask

    task automatic test_toggle_valid();
        int cyc;
        int rdyErr;
        int bad;
        logic [15:0] d;
        logic [15:0] expWord;
        fillPattern(1'b1, 8'h00, 8'h00, 8'h00);
        beginLoad();
        runLoad(1'b1, 300, cyc, rdyErr);
        checks++;
        if (cyc !== 64 + CHK_EN) begin failures++; $display("[TB] FAIL toggle_cycles: got %0d expected %0d", cyc, 64 + CHK_EN); end
        checks++;
        if (rdyErr !== 0) begin failures++; $display("[TB] FAIL toggle_ready: got %0d errors expected 0", rdyErr); end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            expWord = {8'(k), 8'(k * 17)};
            readWord(4'(k), d);
            if (d !== expWord) begin
                bad++;
                $display("[TB] FAIL toggle_mem%0d: got %h expected %h", k, d, expWord);
            end
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL toggle_mem_total: got %0d bad words expected 0", bad); end
    endtask

    task automatic test_checksum();
        int cyc;
        int rdyErr;
`ifdef CHECKSUM_EN
        fillPattern(1'b1, 8'h00, 8'h00, 8'h01);
        beginLoad();
        runLoad(1'b0, 200, cyc, rdyErr);
        checks++;
        if (err !== 1'b1) begin failures++; $display("[TB] FAIL chk_bad_err: got %b expected 1", err); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL chk_bad_done: got %b expected 1", done); end
        fillPattern(1'b1, 8'h00, 8'h00, 8'h00);
        beginLoad();
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL chk_err_cleared: got %b expected 0", err); end
        runLoad(1'b0, 200, cyc, rdyErr);
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL chk_good_err: got %b expected 0", err); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL chk_good_done: got %b expected 1", done); end
`else
        fillPattern(1'b1, 8'h00, 8'h00, 8'h01);
        beginLoad();
        runLoad(1'b0, 200, cyc, rdyErr);
        checks++;
        if (cyc !== 48) begin failures++; $display("[TB] FAIL nochk_cycles: got %0d expected 48", cyc); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL nochk_err: got %b expected 0", err); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("[TB] FAIL nochk_done: got %b expected 1", done); end
`endif
    endtask

    // Scenario sequence; each later scenario relies on RAM contents left by
    // the earlier ones
    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        en       = 1'b0;
        address  = 4'd0;
        mPhase   = 0;
        mWord    = 0;
        mIdx     = 0;
        for (int k = 0; k < 64; k++) seqBytes[k] = 8'h00;

        test_reset();
        test_full_load();
        test_reset_midload();
        test_read_port();
        test_start_control();
        test_toggle_valid();
        test_checksum();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
